// File: rtl/ahb_burst_manager_pkg.sv
// Shared AHB encodings, manager FSM state type and HBURST beat decoding
// for the AHB burst manager.
package AHBCommon_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Zero marks a burst type this manager does not issue.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE: return 5'd1;
            HBURST_INCR4:  return 5'd4;
            HBURST_INCR8:  return 5'd8;
            HBURST_INCR16: return 5'd16;
            default:       return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_manager_addr_gen.sv
// Address arithmetic for the burst manager: next beat address and the
// check that a whole incrementing burst stays inside one 1 KB region.
module ahb_addr_gen
    import AHBCommon_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            cur_size,
    input  logic [9:0]            start_offset,
    input  logic [2:0]            start_size,
    input  logic [4:0]            start_beats,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  crosses_1k
);

    logic [11:0] burst_bytes;
    logic [11:0] burst_end;

    always_comb begin
        next_addr   = cur_addr + (ADDR_WIDTH'(1) << cur_size);
        // 16 beats of the largest HSIZE plus a 1023 offset still fits 12 bits.
        burst_bytes = 12'(start_beats) << start_size;
        burst_end   = 12'(start_offset) + burst_bytes;
        crosses_1k  = burst_end > 12'd1024;
    end

endmodule

// File: rtl/ahb_burst_manager.sv
// AHB manager that turns one command (SINGLE/INCR4/8/16) into a pipelined
// AHB burst, with write-data handshake, read-data return and error abort.
module ahb_burst_manager
    import AHBCommon_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    input  logic [2:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [1:0]            htrans,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
    logic [1:0]              htrans_q, htrans_d;
    logic                    hwrite_q, hwrite_d;
    logic [2:0]              hsize_q, hsize_d;
    logic [2:0]              hburst_q, hburst_d;
    logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
    logic [3:0]              addr_rem_q, addr_rem_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    cmd_ready_q, cmd_ready_d;

    logic                    accept;
    logic [4:0]              cmd_beats;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic                    cmd_illegal;
    logic                    crosses_1k;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    addr_active;
    logic                    addr_done;
    logic                    data_done;

    ahb_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .cur_addr    (haddr_q),
        .cur_size    (hsize_q),
        .start_offset(cmd_addr[9:0]),
        .start_size  (cmd_size),
        .start_beats (cmd_beats),
        .next_addr   (next_addr),
        .crosses_1k  (crosses_1k)
    );

    assign accept      = cmd_valid && cmd_ready_q;
    assign cmd_beats   = burst_beats(cmd_burst);
    assign align_mask  = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
    assign cmd_illegal = (cmd_size > 3'(MAX_SIZE)) || (cmd_beats == 5'd0)
                      || ((cmd_addr & align_mask) != '0) || crosses_1k;

    assign addr_active = (htrans_q == HTRANS_NONSEQ) || (htrans_q == HTRANS_SEQ);
    assign addr_done   = addr_active && hready && !hresp;
    assign data_done   = (state_q == ST_DATA) && hready && !hresp;

    // Handshakes are qualified by this cycle's hready, so they follow the bus directly.
    assign wr_ready = addr_done && hwrite_q;
    assign rd_valid = data_done && !hwrite_q;
    assign rd_data  = hrdata;

    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;
    assign hwdata    = hwdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = cmd_ready_q;

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default of 0) so no path infers a latch.
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        addr_rem_d = addr_rem_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (wr_ready) begin
            hwdata_d = wr_data;
        end

        if (addr_done) begin
            if (addr_rem_q != 4'd0) begin
                haddr_d    = next_addr;
                htrans_d   = HTRANS_SEQ;
                addr_rem_d = addr_rem_q - 4'd1;
            end else begin
                htrans_d = HTRANS_IDLE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_illegal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        haddr_d    = cmd_addr;
                        htrans_d   = HTRANS_NONSEQ;
                        hwrite_d   = cmd_write;
                        hsize_d    = cmd_size;
                        hburst_d   = cmd_burst;
                        addr_rem_d = 4'(cmd_beats - 5'd1);
                        state_d    = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (addr_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hresp) begin
                    // Drop the pending address phase so the subordinate sees IDLE on the second error cycle.
                    htrans_d   = HTRANS_IDLE;
                    addr_rem_d = 4'd0;
                    state_d    = hready ? ST_ERR2 : ST_ERR1;
                end else if (hready && !addr_active) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                if (hready) begin
                    state_d = ST_ERR2;
                end
            end
            ST_ERR2: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hburst_q    <= 3'b000;
            hwdata_q    <= '0;
            addr_rem_q  <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            addr_rem_q  <= addr_rem_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

endmodule
